// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants and slot phase type for the seven-segment scan driver
package seg7_pkg;

    // Active-low glyphs, bit 6 = segment a through bit 0 = segment g
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex to active-low seven-segment glyph decoder
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment driver with frame-aligned updates
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam phase_t PH_RESET = (BLANK_CYCLES > 0) ? PH_BLANK : PH_DRIVE;

    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [IDX_W-1:0]        idx, idx_next;
    phase_t                  phase, phase_next;
    logic                    slot_wrap, frame_wrap;

    logic [4*NUM_DIGITS-1:0] sh_value, act_value;
    logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
    logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
    logic [NUM_DIGITS-1:0]   lzb_mask;
    logic                    pending;

    logic [3:0]              cur_hex;
    logic                    cur_blank, cur_dp, lit;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [6:0]              cur_seg;

    assign slot_wrap  = (cnt == CNT_MAX);
    assign frame_wrap = slot_wrap && (idx == IDX_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            phase <= PH_RESET;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            phase <= phase_next;
        end
    end

    always_comb begin
        cnt_next   = slot_wrap ? '0 : cnt + CNT_W'(1);
        idx_next   = idx;
        if (slot_wrap) begin
            idx_next = frame_wrap ? '0 : idx + IDX_W'(1);
        end
        phase_next = (cnt_next < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
    end

`ifdef SEG7_LZB_EN
    logic seen_nz;

    // Walk down from the top digit; digit 0 is never suppressed so zero shows "0"
    always_comb begin
        lzb_mask = '0;
        seen_nz  = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen_nz     = seen_nz | (sh_value[4*i +: 4] != 4'h0);
            lzb_mask[i] = !seen_nz;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // A load on the boundary cycle still copies the older shadow and stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_value  <= '0;
            sh_blank  <= '1;
            sh_dp     <= '0;
            pending   <= 1'b0;
            act_value <= '0;
            act_blank <= '1;
            act_dp    <= '0;
        end else begin
            if (frame_wrap && pending) begin
                act_value <= sh_value;
                act_blank <= sh_blank | lzb_mask;
                act_dp    <= sh_dp;
            end
            if (load) begin
                sh_value <= value;
                sh_blank <= blank_mask;
                sh_dp    <= dp;
                pending  <= 1'b1;
            end else if (frame_wrap) begin
                pending  <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_hex   = 4'h0;
        cur_blank = 1'b1;
        cur_dp    = 1'b0;
        an_sel    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_hex   = act_value[4*i +: 4];
                cur_blank = act_blank[i];
                cur_dp    = act_dp[i];
                an_sel[i] = 1'b1;
            end
        end
        lit = (phase == PH_DRIVE) && !cur_blank;
    end

    seg7_decode u_decode (
        .hex (cur_hex),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp_n       <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= lit ? cur_seg : SEG_OFF;
            dp_n       <= !(lit && cur_dp);
            an         <= lit ? ~an_sel : '1;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (4 digits, 8-clock slots)
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int PS = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * PS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp = '0;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int         apply_at;
        logic [15:0] v;
        logic [3:0]  b;
        logic [3:0]  d;
    } ld_t;
    ld_t sb[$];

    logic [15:0] cur_v = '0;
    logic [3:0]  cur_b = 4'hF;
    logic [3:0]  cur_d = '0;

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .dp         (dp),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'b0000001;  4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;  4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;  4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;  4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;  4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;  default: glyph = 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] lzb(input logic [15:0] v);
        lzb = 4'b0000;
`ifdef SEG7_LZB_EN
        if (v[15:4] == 12'h0)      lzb = 4'b1110;
        else if (v[15:8] == 8'h0)  lzb = 4'b1100;
        else if (v[15:12] == 4'h0) lzb = 4'b1000;
`endif
    endfunction

    // Per-cycle monitor: outputs after edge n reflect counter state n-1
    int          s, slot, c;
    logic        drv;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn;
    ld_t         e;
    always @(posedge clk) begin
        #2;
        if (rst) begin
            cur_v = '0;
            cur_b = 4'hF;
            cur_d = '0;
        end else if (cyc > 0) begin
            s    = cyc - 1;
            slot = (s / PS) % ND;
            c    = s % PS;
            while (sb.size() > 0 && sb[0].apply_at <= s) begin
                e = sb.pop_front();
                cur_v = e.v;
                cur_b = e.b;
                cur_d = e.d;
            end
            drv   = (c >= BC) && !cur_b[slot];
            e_an  = drv ? ~(4'b0001 << slot) : 4'hF;
            e_seg = drv ? glyph(cur_v[4*slot +: 4]) : 7'h7F;
            e_dpn = drv ? ~cur_d[slot] : 1'b1;
            check("mon_an", an, e_an);
            check("mon_seg", seg, e_seg);
            check("mon_dp_n", dp_n, e_dpn);
            check("mon_frame_done", frame_done, (cyc % FRAME) == 0);
            check("mon_onehot", $countones(~an) <= 1, 1);
        end
    end

    task automatic wait_neg(input int n);
        int k = 0;
        @(negedge clk);
        while (cyc != n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (cyc != n) check("wait_timeout", cyc, n);
    endtask

    // Load is sampled at edge p; it lands at the first frame boundary after p
    task automatic load_at(input int p, input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
        wait_neg(p - 1);
        value      = v;
        blank_mask = b;
        dp         = d;
        load       = 1'b1;
        sb.push_back('{apply_at: (p / FRAME + 1) * FRAME, v: v, b: b | lzb(v), d: d});
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic slot_at(input int n, input string tag, input logic [3:0] xa,
                           input logic [6:0] xs, input logic xd);
        wait_neg(n);
        check({tag, "_an"}, an, xa);
        check({tag, "_seg"}, seg, xs);
        check({tag, "_dp_n"}, dp_n, xd);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        load_at(100, 16'h12AF, 4'b0000, 4'b0010);
        slot_at(132, "dec0", 4'b1110, 7'b0111000, 1'b1);
        slot_at(140, "dec1", 4'b1101, 7'b0001000, 1'b0);
        slot_at(148, "dec2", 4'b1011, 7'b0010010, 1'b1);
        slot_at(156, "dec3", 4'b0111, 7'b1001111, 1'b1);

        load_at(170, 16'h1111, 4'b0000, 4'b0000);
        load_at(210, 16'h2222, 4'b0000, 4'b0000);
        slot_at(220, "tear_old", 4'b0111, 7'b1001111, 1'b1);
        slot_at(228, "tear_new", 4'b1110, 7'b0010010, 1'b1);

        load_at(250, 16'h3333, 4'b0000, 4'b0000);
        load_at(256, 16'h4444, 4'b0000, 4'b0000);
        slot_at(260, "bnd_old", 4'b1110, 7'b0000110, 1'b1);
        slot_at(292, "bnd_new", 4'b1110, 7'b1001100, 1'b1);
        load_at(321, 16'h5555, 4'b0000, 4'b0000);
        slot_at(324, "fd_hold", 4'b1110, 7'b1001100, 1'b1);
        slot_at(356, "fd_new", 4'b1110, 7'b0100100, 1'b1);

        load_at(370, 16'h0005, 4'b0000, 4'b0000);
        slot_at(388, "lzb5_d0", 4'b1110, 7'b0100100, 1'b1);
`ifdef SEG7_LZB_EN
        slot_at(396, "lzb5_d1", 4'b1111, 7'b1111111, 1'b1);
`else
        slot_at(396, "lzb5_d1", 4'b1101, 7'b0000001, 1'b1);
`endif
        load_at(420, 16'h0000, 4'b0000, 4'b0000);
        slot_at(452, "lzb0_d0", 4'b1110, 7'b0000001, 1'b1);
`ifdef SEG7_LZB_EN
        slot_at(460, "lzb0_d1", 4'b1111, 7'b1111111, 1'b1);
`else
        slot_at(460, "lzb0_d1", 4'b1101, 7'b0000001, 1'b1);
`endif

        load_at(490, 16'hBEEF, 4'b0000, 4'b0000);
        wait_neg(500);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_seg", seg, 7'h7F);
        check("mid_rst_an", an, 4'hF);
        check("mid_rst_dp_n", dp_n, 1'b1);
        check("mid_rst_frame_done", frame_done, 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        load_at(100, 16'h9876, 4'b0000, 4'b0000);
        slot_at(132, "post_rst_d0", 4'b1110, 7'b0100000, 1'b1);
        wait_neg(170);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It latches a packed hex value plus per-digit blank and decimal-point masks, then scans one digit at a time at a parameterised rate. Each digit slot starts with an anti-ghosting blank interval, and updates are applied only at frame boundaries, so a displayed frame never tears. It sits between any numeric producer (counters, debug registers) and the board's segment/anode pins.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned (1..8).
- `PRESCALE`, default 50000: clocks per digit slot (≥ `BLANK_CYCLES`+2).
- `BLANK_CYCLES`, default 2: clocks at the start of each slot with all anodes off.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `load`, in, 1: single-cycle strobe that captures `value`, `blank_mask` and `dp` into the shadow registers.
- `value`, in, 4*`NUM_DIGITS`: packed hex digits. Digit 0 is `value[3:0]` and is the rightmost digit.
- `blank_mask`, in, `NUM_DIGITS`: a 1 forces the corresponding digit dark.
- `dp`, in, `NUM_DIGITS`: a 1 lights the decimal point of the corresponding digit.
- `seg`, out, 7: active-low segments, `seg[6]`=a through `seg[0]`=g.
- `dp_n`, out, 1: active-low decimal point.
- `an`, out, `NUM_DIGITS`: active-low anodes; at most one bit is low at any time.
- `frame_done`, out, 1: one-cycle pulse on the cycle the digit index wraps from `NUM_DIGITS`-1 to 0.

## Operation
- **Prescaler `cnt`** counts 0..`PRESCALE`-1 and wraps. When it wraps, digit index `idx` increments modulo `NUM_DIGITS`.
- **Slot phases:**
  - BLANK phase while `cnt` < `BLANK_CYCLES`.
  - DRIVE phase otherwise.
  - Transitions: BLANK→DRIVE at `cnt`=`BLANK_CYCLES`; DRIVE→BLANK at the `cnt` wrap.
- **Shadow / active registers:**
  - `load` writes the shadow registers and sets `pending`.
  - At a frame boundary (the `idx` wrap) with `pending` set, shadow is copied to active and `pending` is cleared.
- **`load` coinciding with a boundary:** the copy uses the pre-load shadow contents. The new load is written to shadow, `pending` remains set, and the new data is applied at the next boundary.
- **Back-to-back loads within a frame:** the last one wins.
- **Decode (hex, active-low):**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- **DRIVE phase outputs:**
  - Digit not blanked: `an[idx]`=0, `seg`=decode(active digit), `dp_n`=~`dp[idx]`.
  - Blanked digit or BLANK phase: `an` all 1, `seg`=1111111, `dp_n`=1.

## Timing
- All outputs are registered. Each output reflects the `cnt`/`idx` state of the previous cycle (1-cycle latency).
- **Reset values:**
  - Outputs: `seg`=1111111, `dp_n`=1, `an` all 1, `frame_done`=0.
  - Internal: `cnt`=0, `idx`=0, `pending`=0.
  - Active registers: value=0, blank all 1, dp=0. The display stays dark until the first load has been applied.
- **Reset mid-frame:** outputs go to their reset values immediately (asynchronously). Scanning restarts at digit 0, `cnt`=0, and any pending load is discarded.
- Frame period is `NUM_DIGITS`*`PRESCALE` clocks, with `frame_done` asserted once per frame.
- Load-to-display latency: at most one frame plus one slot.
- `an` is low for exactly `PRESCALE`-`BLANK_CYCLES` cycles per unblanked slot.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking.
  - Active digits above the most significant nonzero digit are blanked, in addition to `blank_mask`.
  - Digit 0 is never blanked by this rule, so value 0 displays "0".
  - The LZB mask is computed when shadow is copied to active.
- `SEG7_LZB_EN` undefined: only `blank_mask` blanks digits.

## Structure
- **Package `seg7_pkg`:**
  - The 16 segment glyph constants and the all-off constant `SEG_OFF`=1111111.
  - Slot phase enum (BLANK, DRIVE).
- **Sub-module `seg7_decode`:** combinational, 4-bit in, 7-bit active-low out, implemented from the package constants. It is instantiated once on the selected digit.

## Test plan
Bench parameters: `NUM_DIGITS`=4, `PRESCALE`=8, `BLANK_CYCLES`=2.

1. **Reset:** hold `rst` → `seg`=1111111, `an`=1111, `dp_n`=1, `frame_done`=0. After release with no load, `an` stays 1111 for 3 frames.
2. **Decode and scan order:** `load` `value`=16'h12AF, `blank_mask`=0, `dp`=0010 → after the next boundary:
   - slot 0: `an`=1110, `seg`=0111000;
   - slot 1: `an`=1101, `seg`=0001000, `dp_n`=0;
   - slot 2: `an`=1011, `seg`=0010010;
   - slot 3: `an`=0111, `seg`=1001111.
3. **Tear-free update:** load 16'h1111, then load 16'h2222 during slot 2 → slots 2–3 still show "1"; the next frame shows "2" on all digits. A load on the `frame_done` cycle appears one frame later.
4. **Blank interval and frame timing:** `an`=1111 for exactly 2 cycles at the start of each slot; `frame_done` pulses every 32 cycles; `an` never has two bits low.
5. **LZB:** `value`=16'h0005.
   - With `SEG7_LZB_EN`: `an[3:1]` never low; digit 0 `seg`=0100100.
   - Without: digits 3..1 show 0000001.
   - `value`=0 with the macro: digit 0 shows 0000001.
6. **Mid-frame reset:** assert `rst` for 1 cycle during slot 2 → outputs reach reset values within the same cycle; scanning restarts at digit 0; the display stays dark until a new load is applied.
